ntt_cmd_ctrl: RTL and testbench
===============================

NTT_CMD_CTRL -- requirements
Module: ntt_cmd_ctrl

Interface
REQ-001 Parameter N_LOG2, default 8, log2 of transform length (N=256).
REQ-002 Parameter PIPE_LAT, default 4, butterfly/memory pipeline depth drained after last issue.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  command strobe, level; may be held high several cycles.
REQ-006 set_state  input  3  command code, sampled with start.
REQ-007 busy  output  1  command in progress.
REQ-008 done  output  1  one-cycle pulse, command completed.
REQ-009 err  output  1  one-cycle pulse, illegal command code.
REQ-010 op_mode  output  3  latched code of the last accepted command.
REQ-011 bfu_en  output  1  issue enable to both butterfly units and memory address generator.
REQ-012 stage  output  3  current NTT/INTT stage.
REQ-013 idx  output  N_LOG2-1  issue index within stage or sweep.

Function
REQ-014 Register start_d = start delayed one cycle; command accepted in cycle where start=1, start_d=0, FSM in IDLE.
REQ-015 Start rising edge while FSM not IDLE, or start held high, shall be ignored; no queuing.
REQ-016 Codes: 000 NOP, 001 NTT, 010 pointwise multiply (PWM), 011 INTT, 100 read-out (RD); 101-111 illegal.
REQ-017 FSM states IDLE, RUN, DRAIN, FIN; accept legal non-NOP: IDLE->RUN; end of issue: RUN->DRAIN; after PIPE_LAT cycles: DRAIN->FIN; FIN->IDLE after one cycle.
REQ-018 On accept, op_mode loads set_state (legal codes only) and holds until next accepted legal command.
REQ-019 RUN: bfu_en=1 every cycle, busy=1; first RUN cycle is accept cycle +1 with idx=0.
REQ-020 NTT: 2 butterflies per cycle, N/4=64 issues per stage, idx counts 0..63, stage ascends 0..7; idx wraps 63->0 with stage+1; RUN lasts 512 cycles.
REQ-021 INTT: same idx sequence, stage descends 7..0; wrap 63->0 with stage-1; 512 cycles.
REQ-022 PWM and RD: stage held 0, idx counts 0..127 (2 coefficients per cycle), RUN lasts 128 cycles.
REQ-023 DRAIN: bfu_en=0, busy=1, idx and stage hold last value, exactly PIPE_LAT cycles; PIPE_LAT=0 skips DRAIN.
REQ-024 FIN: done=1 for one cycle, busy=0; idx and stage return to 0 in the same cycle.
REQ-025 NOP: no RUN; done=1 in accept cycle +1, busy stays 0, bfu_en stays 0.
REQ-026 Illegal code: err=1 in accept cycle +1, no done, no bfu_en, op_mode unchanged, FSM stays IDLE.
REQ-027 New start edge in FIN cycle ignored; earliest next accept is cycle after FIN.
REQ-028 Counters sized exactly; no overflow beyond the ranges above; stage never leaves 0..7.

Reset
REQ-029 rst=1 forces asynchronously: FSM IDLE, start_d=0, busy=0, done=0, err=0, bfu_en=0, stage=0, idx=0, op_mode=000.
REQ-030 rst asserted mid-command aborts it with no done pulse; after release, start held high shall not be accepted until it falls and rises again (start_d reset then sampled).

Verification
REQ-031 set_state=001, start high 3 cycles, accept at T -> bfu_en high exactly cycles T+1..T+512, stage 0..7 ascending with 64 cycles each, done pulse at T+517, exactly one done.
REQ-032 set_state=011 -> stage sequence 7,6,...,0, idx 0..63 per stage, done at T+517.
REQ-033 set_state=010 then 100 back-to-back -> each 128 bfu_en cycles, idx 0..127, done at T+133; second start during first command busy ignored.
REQ-034 set_state=000 -> done at T+1, bfu_en never high; set_state=110 -> err at T+1, op_mode unchanged, no done.
REQ-035 rst asserted at NTT RUN cycle 200 with start still high -> all outputs 0 immediately, no done; after release no command until new start rising edge.
REQ-036 Randomized start/set_state over 10k cycles -> done count equals legal accepted commands, busy and done never both 1, bfu_en only while busy.

Source files
------------

// File: rtl/ntt_cmd_if.sv
// Command/status bundle between a host sequencer and the NTT command controller.
// The host drives start/set_state; the controller drives everything else.
interface ntt_cmd_if #(
  parameter int N_LOG2 = 8
);
  logic              start;
  logic [2:0]        set_state;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        op_mode;
  logic              bfu_en;
  logic [2:0]        stage;
  logic [N_LOG2-2:0] idx;

  modport master (
    output start, set_state,
    input  busy, done, err, op_mode, bfu_en, stage, idx
  );

  modport slave (
    input  start, set_state,
    output busy, done, err, op_mode, bfu_en, stage, idx
  );
endinterface

// File: rtl/ntt_cmd_ctrl.sv
// NTT command controller: accepts edge-triggered commands and sequences the
// butterfly issue enable, stage and index through RUN, DRAIN and FIN.
module ntt_cmd_ctrl #(
  parameter int N_LOG2   = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic     clk,
  input  logic     rst,
  ntt_cmd_if.slave cmd
);
  localparam int IW = N_LOG2 - 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [IW-1:0] STAGE_LAST_IDX = IW'((1 << (N_LOG2 - 2)) - 1);
  localparam logic [IW-1:0] IDX_ONE        = IW'(1);
  localparam logic [2:0]    LAST_STAGE     = 3'(N_LOG2 - 1);

  localparam logic [2:0] CODE_NOP  = 3'd0;
  localparam logic [2:0] CODE_NTT  = 3'd1;
  localparam logic [2:0] CODE_INTT = 3'd3;
  localparam logic [2:0] CODE_RD   = 3'd4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t          state_reg;
  logic            start_d_reg;
  logic            armed_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            err_reg;
  logic            bfu_en_reg;
  logic [2:0]      op_mode_reg;
  logic [2:0]      stage_reg;
  logic [IW-1:0]   idx_reg;
  logic [DW-1:0]   drain_cnt_reg;

  logic accept;
  logic is_intt;
  logic is_xform;
  logic last_issue;

  // armed_reg blocks the first post-reset cycle so a start held through reset
  // is only seen as a level, never as a fresh edge.
  always_comb begin
    accept   = cmd.start && !start_d_reg && armed_reg && (state_reg == IDLE);
    is_intt  = (op_mode_reg == CODE_INTT);
    is_xform = (op_mode_reg == CODE_NTT) || is_intt;
    if (is_xform) begin
      last_issue = (idx_reg == STAGE_LAST_IDX) &&
                   (stage_reg == (is_intt ? 3'd0 : LAST_STAGE));
    end else begin
      last_issue = &idx_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      start_d_reg   <= 1'b0;
      armed_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      bfu_en_reg    <= 1'b0;
      op_mode_reg   <= CODE_NOP;
      stage_reg     <= 3'd0;
      idx_reg       <= '0;
      drain_cnt_reg <= '0;
    end else begin
      start_d_reg <= cmd.start;
      armed_reg   <= 1'b1;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (cmd.set_state > CODE_RD) begin
              err_reg <= 1'b1;
            end else begin
              op_mode_reg <= cmd.set_state;
              if (cmd.set_state == CODE_NOP) begin
                state_reg <= FIN;
                done_reg  <= 1'b1;
              end else begin
                state_reg  <= RUN;
                busy_reg   <= 1'b1;
                bfu_en_reg <= 1'b1;
                idx_reg    <= '0;
                stage_reg  <= (cmd.set_state == CODE_INTT) ? LAST_STAGE : 3'd0;
              end
            end
          end
        end
        RUN: begin
          if (last_issue) begin
            bfu_en_reg <= 1'b0;
            if (PIPE_LAT == 0) begin
              state_reg <= FIN;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              idx_reg   <= '0;
              stage_reg <= 3'd0;
            end else begin
              state_reg     <= DRAIN;
              drain_cnt_reg <= DW'(PIPE_LAT - 1);
            end
          end else if (is_xform && (idx_reg == STAGE_LAST_IDX)) begin
            idx_reg   <= '0;
            stage_reg <= is_intt ? (stage_reg - 3'd1) : (stage_reg + 3'd1);
          end else begin
            idx_reg <= idx_reg + IDX_ONE;
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == '0) begin
            state_reg <= FIN;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            idx_reg   <= '0;
            stage_reg <= 3'd0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - DW'(1);
          end
        end
        FIN:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd.busy    = busy_reg;
  assign cmd.done    = done_reg;
  assign cmd.err     = err_reg;
  assign cmd.bfu_en  = bfu_en_reg;
  assign cmd.op_mode = op_mode_reg;
  assign cmd.stage   = stage_reg;
  assign cmd.idx     = idx_reg;
endmodule

// File: tb/tb_ntt_cmd_ctrl.sv
// Bench for ntt_cmd_ctrl: command table, directed corner sequences and a
// randomized run, all checked against a cycle-offset reference model.
module tb_ntt_cmd_ctrl;
  localparam int N_LOG2   = 8;
  localparam int PIPE_LAT = 4;
  localparam int NQ       = (1 << N_LOG2) / 4;
  localparam int XF_RUN   = N_LOG2 * NQ;
  localparam int SW_RUN   = (1 << N_LOG2) / 2;
  localparam int OW       = 10 + N_LOG2 - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ntt_cmd_if #(.N_LOG2(N_LOG2)) cmd();

  ntt_cmd_ctrl #(.N_LOG2(N_LOG2), .PIPE_LAT(PIPE_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .cmd (cmd)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: remembers the edge a command was accepted on and derives
  // every output from the offset since then.
  int         cyc = 0;
  int         acc_e = 0;
  int         err_e = -10;
  logic       active = 1'b0;
  logic [2:0] act_code = 3'd0;
  logic [2:0] op_m = 3'd0;
  logic       prev_start = 1'b0;
  logic       fresh = 1'b1;
  logic       idle_m;
  logic       accept_m;
  int         n_legal = 0;
  int         n_done_seen = 0;
  logic [OW-1:0] got_v, exp_v;

  function automatic int run_len(input logic [2:0] c);
    return (c == 3'd1 || c == 3'd3) ? XF_RUN : SW_RUN;
  endfunction

  function automatic int fin_len(input logic [2:0] c);
    return (c == 3'd0) ? 1 : run_len(c) + PIPE_LAT + 1;
  endfunction

  function automatic logic [OW-1:0] model_out(input int e);
    logic b, d, er, bf;
    logic [2:0] st;
    logic [N_LOG2-2:0] ix;
    int kc, j, rl;
    b = 0; d = 0; bf = 0; st = 0; ix = 0; j = 0;
    er = (err_e == e);
    if (active) begin
      kc = e - acc_e + 1;
      rl = run_len(act_code);
      if (act_code == 3'd0) begin
        d = (kc == 1);
      end else begin
        if (kc >= 1 && kc <= rl) begin
          bf = 1; b = 1; j = kc - 1;
        end else if (kc > rl && kc <= rl + PIPE_LAT) begin
          b = 1; j = rl - 1;
        end
        d = (kc == fin_len(act_code));
        if (b) begin
          if (act_code == 3'd1 || act_code == 3'd3) begin
            st = (act_code == 3'd3) ? 3'(N_LOG2 - 1 - j / NQ) : 3'(j / NQ);
            ix = (N_LOG2-1)'(j % NQ);
          end else begin
            ix = (N_LOG2-1)'(j);
          end
        end
      end
    end
    return {b, d, er, bf, op_m, st, ix};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {cmd.busy, cmd.done, cmd.err, cmd.bfu_en, cmd.op_mode, cmd.stage, cmd.idx};
  endfunction

  always begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      active = 0; prev_start = 0; fresh = 1; op_m = 0; err_e = -10;
    end else begin
      idle_m   = !active || ((cyc - acc_e) > fin_len(act_code));
      accept_m = cmd.start && !prev_start && !fresh && idle_m;
      prev_start = cmd.start;
      fresh = 0;
      if (accept_m) begin
        if (cmd.set_state > 3'd4) begin
          err_e = cyc;
        end else begin
          active = 1; acc_e = cyc; act_code = cmd.set_state; op_m = cmd.set_state;
          n_legal++;
        end
      end
    end
    #1;
    exp_v = model_out(cyc);
    got_v = dut_out();
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL model_cycle %0d: got {busy,done,err,bfu,op,stage,idx}=%h, expected %h", cyc, got_v, exp_v);
    end
    n_vec++;
    if ((cmd.busy && cmd.done) || (cmd.bfu_en && !cmd.busy)) begin
      n_err++;
      $display("FAIL invariant_cycle %0d: busy=%0b done=%0b bfu_en=%0b, required busy&done=0 and bfu_en implies busy",
               cyc, cmd.busy, cmd.done, cmd.bfu_en);
    end
    if (cmd.done) n_done_seen++;
  end

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0] code;
    int         hold;
    int         done_at;
    int         err_at;
    int         bfu_cnt;
    logic [2:0] op;
  } vec_t;

  vec_t vt[9];

  task automatic run_vec(input vec_t v, input int row);
    int done_at, err_at, n_done, n_errp, n_bfu;
    string tag;
    done_at = -1; err_at = -1; n_done = 0; n_errp = 0; n_bfu = 0;
    @(negedge clk);
    cmd.start = 1; cmd.set_state = v.code;
    for (int kc = 1; kc <= 600; kc++) begin
      @(negedge clk);
      if (kc >= v.hold) cmd.start = 0;
      if (cmd.done) begin n_done++; if (done_at < 0) done_at = kc; end
      if (cmd.err)  begin n_errp++; if (err_at < 0) err_at = kc; end
      if (cmd.bfu_en) n_bfu++;
    end
    tag = $sformatf("row%0d_code%0d", row, v.code);
    check_int({tag, "_done_at"}, done_at, v.done_at);
    check_int({tag, "_done_cnt"}, n_done, (v.done_at > 0) ? 1 : 0);
    check_int({tag, "_err_at"}, err_at, v.err_at);
    check_int({tag, "_err_cnt"}, n_errp, (v.err_at > 0) ? 1 : 0);
    check_int({tag, "_bfu_cnt"}, n_bfu, v.bfu_cnt);
    check_int({tag, "_op_mode"}, int'(cmd.op_mode), int'(v.op));
    $display("vector row %0d code=%0d: done_at=%0d err_at=%0d bfu=%0d op=%0d",
             row, v.code, done_at, err_at, n_bfu, cmd.op_mode);
  endtask

  initial begin
    int d1, d2, nd, nb, busy_cnt;
    vt[0] = '{3'd1, 3, 517, -1, 512, 3'd1};
    vt[1] = '{3'd3, 1, 517, -1, 512, 3'd3};
    vt[2] = '{3'd2, 2, 133, -1, 128, 3'd2};
    vt[3] = '{3'd4, 1, 133, -1, 128, 3'd4};
    vt[4] = '{3'd0, 1,   1, -1,   0, 3'd0};
    vt[5] = '{3'd6, 1,  -1,  1,   0, 3'd0};
    vt[6] = '{3'd4, 1, 133, -1, 128, 3'd4};
    vt[7] = '{3'd5, 2,  -1,  1,   0, 3'd4};
    vt[8] = '{3'd7, 1,  -1,  1,   0, 3'd4};

    cmd.start = 0; cmd.set_state = 0;
    @(posedge clk); #1;
    check_int("reset_outputs", int'(dut_out()), 0);
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);

    foreach (vt[i]) run_vec(vt[i], i);

    // PWM then RD; start edges during busy and during FIN must be ignored.
    d1 = -1; d2 = -1; nd = 0; nb = 0;
    @(negedge clk);
    cmd.start = 1; cmd.set_state = 3'd2;
    for (int kc = 1; kc <= 300; kc++) begin
      @(negedge clk);
      cmd.set_state = 3'd4;
      cmd.start = (kc == 50 || kc == 133 || kc == 135);
      if (cmd.done) begin nd++; if (d1 < 0) d1 = kc; else if (d2 < 0) d2 = kc; end
      if (cmd.bfu_en) nb++;
    end
    check_int("b2b_first_done", d1, 133);
    check_int("b2b_second_done", d2, 268);
    check_int("b2b_done_cnt", nd, 2);
    check_int("b2b_bfu_cnt", nb, 256);
    check_int("b2b_op_mode", int'(cmd.op_mode), 4);
    $display("sequence back_to_back: done at %0d and %0d, bfu=%0d", d1, d2, nb);

    // Abort an NTT at RUN cycle 200 with start still held high.
    nd = 0; busy_cnt = 0;
    @(negedge clk);
    cmd.start = 1; cmd.set_state = 3'd1;
    for (int kc = 1; kc <= 200; kc++) begin
      @(negedge clk);
      if (cmd.done) nd++;
    end
    check_int("abort_pre_idx", int'(cmd.idx), 199 % NQ);
    check_int("abort_pre_stage", int'(cmd.stage), 199 / NQ);
    rst = 1;
    #1;
    check_int("abort_outputs_zero", int'(dut_out()), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd.busy || cmd.bfu_en) busy_cnt++;
      if (cmd.done) nd++;
    end
    check_int("abort_held_start_ignored", busy_cnt, 0);
    check_int("abort_no_done", nd, 0);
    cmd.start = 0;
    @(negedge clk);
    cmd.start = 1;
    @(negedge clk);
    cmd.start = 0;
    check_int("reaccept_bfu_en", int'(cmd.bfu_en), 1);
    check_int("reaccept_idx", int'(cmd.idx), 0);
    nd = 0;
    for (int kc = 2; kc <= 600; kc++) begin
      @(negedge clk);
      if (cmd.done) nd++;
    end
    check_int("reaccept_done_cnt", nd, 1);
    $display("sequence abort: held start ignored cycles=%0d, done after reaccept=%0d", 20 - busy_cnt, nd);

    // Randomized commands; the per-cycle model does the detailed checking.
    cmd.start = 0;
    @(negedge clk);
    n_legal = 0; n_done_seen = 0;
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) cmd.start = ~cmd.start;
      cmd.set_state = 3'($urandom_range(0, 7));
    end
    cmd.start = 0;
    repeat (600) @(negedge clk);
    check_int("random_done_vs_accepts", n_done_seen, n_legal);
    $display("random phase: %0d legal accepts, %0d done pulses", n_legal, n_done_seen);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
